// File: rtl/clk_tick_gen_if.sv
// clk_tick_gen_if: valid/ready configuration port for clk_tick_gen.
// Carries cfg_valid, cfg_ch, cfg_div, cfg_mode (master->slave) and cfg_ready (slave->master).
interface clk_tick_gen_if #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 26
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_mode;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      output cfg_mode,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      input  cfg_mode,
      output cfg_ready
   );
endinterface

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: NUM_CH runtime-programmable clock dividers (toggle or pulse mode).
// Ports: in_clk, reset (async high), ch_en, cfg (slave), out_clk, tick.
module clk_tick_gen #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 26,
   parameter int DEFAULT_DIV = 25_000_000,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              in_clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   clk_tick_gen_if.slave     cfg,
   output logic [NUM_CH-1:0] out_clk,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0]  cnt  [NUM_CH];
   logic [CNT_W-1:0]  div  [NUM_CH];
   logic [CNT_W-1:0]  pdiv [NUM_CH];
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] pmode;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] sel;
   logic [CNT_W-1:0]  wdiv;
   logic              ready;

   // Out-of-range channel numbers always look ready so the
   // request is swallowed instead of stalling the master.
   always_comb begin
      ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (32'(cfg.cfg_ch) == i) ready = ~pend[i];
      end
   end

   assign cfg.cfg_ready = ready;
   assign wdiv = (cfg.cfg_div == '0) ? ONE : cfg.cfg_div;

   always_comb begin
      hit = '0;
      sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = ch_en[i] && (cnt[i] == div[i] - ONE);
         sel[i] = cfg.cfg_valid && ready
                  && (32'(cfg.cfg_ch) == i);
      end
   end

   // A new config only lands while cnt is being cleared, so the
   // counter can never sit above a freshly shrunk div-1.
   always_ff @(posedge in_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]  <= '0;
            div[i]  <= DIV_RST;
            pdiv[i] <= '0;
         end
         mode    <= '0;
         pmode   <= '0;
         pend    <= '0;
         out_clk <= '0;
         tick    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            unique case (1'b1)
               !ch_en[i]: begin
                  cnt[i]     <= '0;
                  tick[i]    <= 1'b0;
                  out_clk[i] <= 1'b0;
                  if (pend[i]) begin
                     div[i]  <= pdiv[i];
                     mode[i] <= pmode[i];
                     pend[i] <= 1'b0;
                  end
               end
               hit[i]: begin
                  cnt[i]  <= '0;
                  tick[i] <= 1'b1;
                  // Switching into pulse mode starts from a low output.
                  if (pend[i] && pmode[i])
                     out_clk[i] <= 1'b0;
                  else if (mode[i])
                     out_clk[i] <= 1'b1;
                  else
                     out_clk[i] <= ~out_clk[i];
                  if (pend[i]) begin
                     div[i]  <= pdiv[i];
                     mode[i] <= pmode[i];
                     pend[i] <= 1'b0;
                  end
               end
               (ch_en[i] && !hit[i]): begin
                  cnt[i]  <= cnt[i] + ONE;
                  tick[i] <= 1'b0;
                  if (mode[i]) out_clk[i] <= 1'b0;
               end
            endcase
            // Acceptance needs pend clear, so it never meets an apply.
            if (sel[i]) begin
               pdiv[i]  <= wdiv;
               pmode[i] <= cfg.cfg_mode;
               pend[i]  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: randomized self-checking bench for clk_tick_gen.
// Drives ch_en and the cfg interface; compares against a cycle model.
module tb_clk_tick_gen;

   localparam int NCH = 4;
   localparam int CW  = 26;
   localparam int HW  = 3;

   logic           in_clk;
   logic           reset;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] out_clk;
   logic [NCH-1:0] tick;

   clk_tick_gen_if #(.CH_W(HW), .CNT_W(CW)) cfg ();

   clk_tick_gen #(
      .NUM_CH(NCH),
      .CNT_W(CW),
      .DEFAULT_DIV(4),
      .CH_W(HW)
   ) dut (
      .in_clk(in_clk),
      .reset(reset),
      .ch_en(ch_en),
      .cfg(cfg.slave),
      .out_clk(out_clk),
      .tick(tick)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int n_chk;
   int n_fail;

   // Reference: per channel, edges since the last tick (age),
   // active and queued settings, and the expected outputs.
   int             m_age  [NCH];
   int             m_div  [NCH];
   int             m_pdiv [NCH];
   bit             m_mode [NCH];
   bit             m_pmode[NCH];
   bit             m_pend [NCH];
   logic [NCH-1:0] m_out;
   logic [NCH-1:0] m_tick;
   logic           rdy_obs;
   logic           exp_rdy;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_age[i]   = 0;
         m_div[i]   = 4;
         m_pdiv[i]  = 0;
         m_mode[i]  = 0;
         m_pmode[i] = 0;
         m_pend[i]  = 0;
      end
      m_out  = '0;
      m_tick = '0;
   endtask

   task automatic model_edge();
      bit acc;
      for (int i = 0; i < NCH; i++) begin
         acc = cfg.cfg_valid && (int'(cfg.cfg_ch) == i) && !m_pend[i];
         if (!ch_en[i]) begin
            m_age[i]  = 0;
            m_tick[i] = 1'b0;
            m_out[i]  = 1'b0;
            if (m_pend[i]) begin
               m_div[i]  = m_pdiv[i];
               m_mode[i] = m_pmode[i];
               m_pend[i] = 0;
            end
         end else if (m_age[i] + 1 == m_div[i]) begin
            m_age[i]  = 0;
            m_tick[i] = 1'b1;
            if (m_pend[i] && m_pmode[i]) m_out[i] = 1'b0;
            else m_out[i] = m_mode[i] ? 1'b1 : ~m_out[i];
            if (m_pend[i]) begin
               m_div[i]  = m_pdiv[i];
               m_mode[i] = m_pmode[i];
               m_pend[i] = 0;
            end
         end else begin
            m_age[i]  = m_age[i] + 1;
            m_tick[i] = 1'b0;
            if (m_mode[i]) m_out[i] = 1'b0;
         end
         if (acc) begin
            m_pend[i]  = 1;
            m_pdiv[i]  = (int'(cfg.cfg_div) == 0) ? 1 : int'(cfg.cfg_div);
            m_pmode[i] = cfg.cfg_mode;
         end
      end
   endtask

   // Advance one clock: latch ready just before the edge,
   // step the model, then land 1 time unit past the edge.
   task automatic step();
      #1;
      rdy_obs = cfg.cfg_ready;
      exp_rdy = (int'(cfg.cfg_ch) < NCH) ? !m_pend[int'(cfg.cfg_ch)] : 1'b1;
      model_edge();
      @(posedge in_clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ch_en = '0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_ch    = '0;
      cfg.cfg_div   = '0;
      cfg.cfg_mode  = 1'b0;
      repeat (3) @(posedge in_clk);
      #1;
      n_chk++;
      if ({out_clk, tick} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_out: out=%b tick=%b required 0", out_clk, tick);
      end
      n_chk++;
      if (cfg.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rdy: rdy=%b required 1", cfg.cfg_ready);
      end
      model_reset();
      @(negedge in_clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int hi = 0;
      int tk = 0;
      logic [5:0] other = '0;
      ch_en = 4'b0001;
      repeat (24) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL basic: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
         if (out_clk[0]) hi++;
         if (tick[0]) tk++;
         other = other | {out_clk[3:1], tick[3:1]};
      end
      n_chk++;
      if (hi != 12 || tk != 6) begin
         n_fail++;
         $display("FAIL basic_duty: high=%0d ticks=%0d required 12 6", hi, tk);
      end
      n_chk++;
      if (other !== '0) begin
         n_fail++;
         $display("FAIL basic_idle: others=%b required 0", other);
      end
   endtask

   task automatic test_cfg_pulse();
      int tk = 0;
      int bad = 0;
      ch_en = 4'b0011;
      repeat (5) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL pulse_pre: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
      end
      cfg.cfg_ch    = 3'd1;
      cfg.cfg_div   = 26'd3;
      cfg.cfg_mode  = 1'b1;
      cfg.cfg_valid = 1'b1;
      step();
      cfg.cfg_valid = 1'b0;
      step();
      n_chk++;
      if (rdy_obs !== 1'b0) begin
         n_fail++;
         $display("FAIL pulse_stall: rdy=%b required 0", rdy_obs);
      end
      for (int k = 0; k < 10; k++) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL pulse_wait: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
         if (rdy_obs) break;
      end
      n_chk++;
      if (rdy_obs !== 1'b1) begin
         n_fail++;
         $display("FAIL pulse_timeout: rdy=%b required 1", rdy_obs);
      end
      repeat (12) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick}) begin
            n_fail++;
            $display("FAIL pulse_run: out=%b tick=%b required %b %b",
                     out_clk, tick, m_out, m_tick);
         end
         if (tick[1]) tk++;
         if (out_clk[1] !== tick[1]) bad++;
      end
      n_chk++;
      if (tk != 4 || bad != 0) begin
         n_fail++;
         $display("FAIL pulse_rate: ticks=%0d diff=%0d required 4 0", tk, bad);
      end
   endtask

   task automatic test_div_zero();
      int bad = 0;
      logic prev = 1'b0;
      cfg.cfg_ch    = 3'd2;
      cfg.cfg_div   = 26'd0;
      cfg.cfg_mode  = 1'b0;
      cfg.cfg_valid = 1'b1;
      step();
      cfg.cfg_valid = 1'b0;
      step();
      ch_en = 4'b0111;
      repeat (8) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL div0: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
         if (tick[2] !== 1'b1 || out_clk[2] === prev) bad++;
         prev = out_clk[2];
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL div0_wave: bad=%0d required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int stall = 0;
      ch_en = 4'b1111;
      cfg.cfg_ch    = 3'd3;
      cfg.cfg_div   = 26'd5;
      cfg.cfg_mode  = 1'b0;
      cfg.cfg_valid = 1'b1;
      step();
      cfg.cfg_div  = 26'd2;
      cfg.cfg_mode = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL b2b: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
         if (rdy_obs) break;
         stall++;
      end
      n_chk++;
      if (rdy_obs !== 1'b1 || stall == 0) begin
         n_fail++;
         $display("FAIL b2b_stall: rdy=%b stall=%0d required 1 >0", rdy_obs, stall);
      end
      cfg.cfg_ch    = 3'd5;
      cfg.cfg_div   = 26'd9;
      cfg.cfg_mode  = 1'b1;
      step();
      cfg.cfg_valid = 1'b0;
      n_chk++;
      if (rdy_obs !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_rdy: rdy=%b required 1", rdy_obs);
      end
      repeat (12) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL b2b_run: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
      end
   endtask

   task automatic test_disable();
      int n = 0;
      ch_en = 4'b1111;
      for (int k = 0; k < 20; k++) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick}) begin
            n_fail++;
            $display("FAIL dis_pre: out=%b tick=%b required %b %b",
                     out_clk, tick, m_out, m_tick);
         end
         if (out_clk[0]) break;
      end
      n_chk++;
      if (out_clk[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL dis_seek: out0=%b required 1", out_clk[0]);
      end
      ch_en[0] = 1'b0;
      step();
      n_chk++;
      if (out_clk[0] !== 1'b0 || tick[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL dis_off: out0=%b tick0=%b required 0 0", out_clk[0], tick[0]);
      end
      step();
      ch_en[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         n++;
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick}) begin
            n_fail++;
            $display("FAIL dis_run: out=%b tick=%b required %b %b",
                     out_clk, tick, m_out, m_tick);
         end
         if (tick[0]) break;
      end
      n_chk++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL dis_restart: edges=%0d required 4", n);
      end
   endtask

   task automatic test_reset_mid();
      int tk = 0;
      cfg.cfg_ch    = 3'd1;
      cfg.cfg_div   = 26'd7;
      cfg.cfg_mode  = 1'b0;
      cfg.cfg_valid = 1'b1;
      step();
      cfg.cfg_valid = 1'b0;
      step();
      #3;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({out_clk, tick} !== 8'h00) begin
         n_fail++;
         $display("FAIL rmid_out: out=%b tick=%b required 0", out_clk, tick);
      end
      model_reset();
      @(negedge in_clk);
      @(negedge in_clk);
      reset = 1'b0;
      #1;
      n_chk++;
      if (cfg.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_rdy: rdy=%b required 1", cfg.cfg_ready);
      end
      repeat (12) begin
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL rmid_run: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
         if (tick[1]) tk++;
      end
      n_chk++;
      if (tk != 3) begin
         n_fail++;
         $display("FAIL rmid_div: ticks=%0d required 3", tk);
      end
   endtask

   task automatic test_random();
      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
         cfg.cfg_valid = ($urandom_range(0, 2) == 0);
         cfg.cfg_ch    = HW'($urandom_range(0, 7));
         cfg.cfg_div   = CW'($urandom_range(0, 6));
         cfg.cfg_mode  = 1'($urandom_range(0, 1));
         step();
         n_chk++;
         if ({out_clk, tick} !== {m_out, m_tick} || rdy_obs !== exp_rdy) begin
            n_fail++;
            $display("FAIL random: out=%b tick=%b rdy=%b required %b %b %b",
                     out_clk, tick, rdy_obs, m_out, m_tick, exp_rdy);
         end
      end
      cfg.cfg_valid = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_cfg_pulse();
      test_div_zero();
      test_back_to_back();
      test_disable();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time=%0t required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Multi-channel, runtime-programmable successor to the single fixed-divisor clock divider. It generates NUM_CH independent divided outputs from in_clk, one per channel. Each channel has its own divisor, its own mode (square-wave toggle or single-cycle pulse), an enable, and a per-cycle tick strobe. Divisor and mode are changed at run time through a valid/ready configuration port, and changes take effect glitch-free at the channel's next terminal count. The block sits between the board clock and the FSM/display logic that need slow enables.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- CNT_W, 26, counter/divisor width in bits
- DEFAULT_DIV, 25_000_000, divisor loaded into every channel at reset (must fit in CNT_W)
- CH_W, $clog2(NUM_CH) (min 1), width of cfg_ch

Ports:
- in_clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- ch_en  input  NUM_CH  per-channel run enable, bit i = channel i
- cfg_valid  input  1  configuration request valid
- cfg_ready  output  1  block can accept a request for the channel currently on cfg_ch
- cfg_ch  input  CH_W  target channel; values ≥ NUM_CH are accepted and discarded
- cfg_div  input  CNT_W  new divisor; 0 is stored as 1
- cfg_mode  input  1  0 = toggle (square wave), 1 = pulse
- out_clk  output  NUM_CH  divided clock/pulse output per channel (registered)
- tick  output  NUM_CH  one-cycle strobe at each terminal count (registered)

## Operation
- Per-channel state: cnt[CNT_W], div[CNT_W], mode, pend_div, pend_mode, pending flag.
- Reset puts every channel in this state: cnt=0, div=DEFAULT_DIV, mode=0, pending=0, out_clk=0, tick=0.
- Running, with ch_en[i]=1:
  - When cnt==div-1 (terminal count), cnt returns to 0 and tick[i] pulses high for one cycle.
  - Otherwise cnt increments.
- Output behaviour at terminal count:
  - Mode 0: out_clk[i] toggles.
  - Mode 1: out_clk[i] equals tick[i].
- Disabled, with ch_en[i]=0: cnt goes to 0, tick[i] goes to 0 and out_clk[i] goes to 0 on the next edge, and all three hold there. Re-enabling restarts from cnt=0.
- Configuration handshake:
  - cfg_ready = ~pending[cfg_ch]. For out-of-range cfg_ch, cfg_ready = 1.
  - A transfer occurs on a rising edge with cfg_valid & cfg_ready. It writes pend_div/pend_mode and sets pending for that channel.
- Applying a pending configuration (pending[i]=1):
  - If the channel is enabled, the new values load at its next terminal count. On that edge cnt=0, div and mode are updated, and pending is cleared. tick still pulses on that edge.
  - If the channel is disabled, the new values load on the next edge.
  - If the new mode is 1, out_clk is forced 0 when it is applied.
- Requests to different channels are independent. A channel with a pending update never blocks the others.
- Divisor arithmetic is unsigned CNT_W bits. Comparison uses div-1, which never underflows because div≥1.
- The counter never wraps past div-1. If div changes, cnt is already 0, so no overrun is possible.

## Timing
- Mode 0 output period = 2·div in_clk cycles with exactly 50% duty. Mode 1 output high for 1 cycle every div cycles.
- div=1:
  - Mode 0: out_clk toggles every cycle (in_clk/2).
  - Mode 1: tick and out_clk are held high continuously.
- From enable: if ch_en rises before edge E0, the first tick is high after edge E0+div-1, i.e. div enabled edges including E0.
- Config latency: cfg_ready for that channel drops on the edge after acceptance. It rises on the edge that applies the change (disabled channel: one cycle later).
- Simultaneous events:
  - Acceptance on the same edge as the channel's terminal count: counts as pending, and it applies at the following terminal count.
  - ch_en deasserting while pending: the config applies on the next edge.
- Reset asserted mid-operation clears all state immediately, including pending requests, which are lost. No tick is generated on reset release.

## Test plan
- Reset, then DEFAULT_DIV overridden to 4, ch_en=4'b0001 → out_clk[0] period 8 cycles, 4 high/4 low; tick[0] every 4 cycles; channels 1-3 stay 0.
- Write ch1 div=3 mode=1 while enabled → cfg_ready low until ch1's next terminal count; afterwards out_clk[1]=tick[1] high 1 of every 3 cycles; ch0 waveform unaffected throughout.
- cfg_div=0 mode 0 on ch2, then enable → out_clk[2] toggles every cycle, tick[2] constantly 1.
- Back-to-back cfg_valid to ch3 twice → second request stalls (cfg_ready=0) until first applies; cfg_ch=5 with NUM_CH=4 → accepted with no effect.
- Drop ch_en[0] mid-period with out_clk[0]=1 → next edge out_clk[0]=0, cnt=0; re-enable → first tick after exactly div edges.
- Assert reset mid-period with a pending write → all outputs 0 at once, cfg_ready=1 after release, divisors back to DEFAULT_DIV.
